// File: rtl/ccff_chain_sequencer.sv
// ccff_chain_sequencer: programs or rotates/reads back the ccff scan chain, gating prog_clk and driving IO isolation.
module ccff_chain_sequencer #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              rd_mode,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en,
  output logic              isol_n,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int WB_W = $clog2(WORD_W + 1);
  typedef enum logic [2:0] {IDLE, PLOAD, PSHIFT, RSHIFT, RHOLD, FIN} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d, rem;
  logic [WB_W-1:0]   wbits_q, wbits_d;
  logic [WORD_W-1:0] sreg_q, sreg_d, rd_data_q, rd_data_d, cap;
  logic              clk_en_q, clk_en_d, rd_valid_q, rd_valid_d, isol_n_q, isol_n_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, prog_q, prog_d;
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    wbits_d    = wbits_q;
    sreg_d     = sreg_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    isol_n_d   = isol_n_q;
    busy_d     = busy_q;
    err_d      = err_q | (start & busy_q);
    prog_d     = prog_q;
    cap        = {rd_data_q[WORD_W-2:0], ccff_tail};
    rem        = CNT_W'(CHAIN_LEN) - bitcnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = rd_mode ? RSHIFT : PLOAD;
        busy_d   = 1'b1;
        err_d    = 1'b0;
        prog_d   = !rd_mode;
        bitcnt_d = '0;
        wbits_d  = '0;
        isol_n_d = rd_mode & isol_n_q;
      end
      PLOAD: if (cfg_valid) begin
        sreg_d  = cfg_data;
        wbits_d = (rem < CNT_W'(WORD_W)) ? WB_W'(rem) : WB_W'(WORD_W);
        state_d = PSHIFT;
      end
      PSHIFT: begin
        sreg_d   = sreg_q << 1;
        bitcnt_d = bitcnt_q + CNT_W'(1);
        wbits_d  = wbits_q - WB_W'(1);
        if (wbits_q == WB_W'(1)) state_d = (bitcnt_d == CNT_W'(CHAIN_LEN)) ? FIN : PLOAD;
      end
      RSHIFT: begin
        bitcnt_d  = bitcnt_q + CNT_W'(1);
        wbits_d   = wbits_q + WB_W'(1);
        rd_data_d = cap;
        // a short final word is pushed up to the MSB end, zero-filling below
        if (wbits_d == WB_W'(WORD_W) || bitcnt_d == CNT_W'(CHAIN_LEN)) begin
          rd_data_d  = cap << (WB_W'(WORD_W) - wbits_d);
          rd_valid_d = 1'b1;
          state_d    = RHOLD;
        end
      end
      RHOLD: if (rd_ready) begin
        rd_valid_d = 1'b0;
        wbits_d    = '0;
        state_d    = (bitcnt_q == CNT_W'(CHAIN_LEN)) ? FIN : RSHIFT;
      end
      FIN: begin
        busy_d   = 1'b0;
        isol_n_d = isol_n_q | prog_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    clk_en_d = (state_d == PSHIFT) || (state_d == RSHIFT);
    done_d   = (state_d == FIN);
  end
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      wbits_q    <= '0;
      sreg_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      clk_en_q   <= 1'b0;
      isol_n_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      prog_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      wbits_q    <= wbits_d;
      sreg_q     <= sreg_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      clk_en_q   <= clk_en_d;
      isol_n_q   <= isol_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      prog_q     <= prog_d;
    end
  end
  assign cfg_ready    = (state_q == PLOAD);
  assign ccff_head    = (state_q == RSHIFT) ? ccff_tail : sreg_q[WORD_W-1];
  assign chain_clk_en = clk_en_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign isol_n       = isol_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
endmodule

// File: tb/tb_ccff_chain_sequencer.sv
// tb_ccff_chain_sequencer: drives a 16-bit and a 12-bit chain instance against behavioural chain models.
module tb_ccff_chain_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic start = 1'b0, rd_mode = 1'b0, cfg_valid = 1'b0, rd_ready = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic a_ready, a_rv, a_head, a_en, a_isol, a_busy, a_done, a_err;
  logic b_ready, b_rv, b_head, b_en, b_isol, b_busy, b_done, b_err;
  logic [7:0] a_rd, b_rd;
  logic [15:0] ch_a = '0;
  logic [11:0] ch_b = '0;
  logic m_ready, m_rv, m_head, m_en, m_isol, m_busy, m_done, m_err;
  logic [7:0] m_rd;
  logic head_q[$];
  logic [7:0] word_q[$];
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  ccff_chain_sequencer #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(16)) dut_a (
    .prog_clk(clk), .pReset(rst_n), .start(start & ~sel), .rd_mode(rd_mode),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid & ~sel), .cfg_ready(a_ready),
    .rd_data(a_rd), .rd_valid(a_rv), .rd_ready(rd_ready & ~sel),
    .ccff_head(a_head), .ccff_tail(ch_a[15]), .chain_clk_en(a_en),
    .isol_n(a_isol), .busy(a_busy), .done(a_done), .err(a_err));

  ccff_chain_sequencer #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(16)) dut_b (
    .prog_clk(clk), .pReset(rst_n), .start(start & sel), .rd_mode(rd_mode),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid & sel), .cfg_ready(b_ready),
    .rd_data(b_rd), .rd_valid(b_rv), .rd_ready(rd_ready & sel),
    .ccff_head(b_head), .ccff_tail(ch_b[11]), .chain_clk_en(b_en),
    .isol_n(b_isol), .busy(b_busy), .done(b_done), .err(b_err));

  assign {m_ready, m_rv, m_head, m_en, m_isol, m_busy, m_done, m_err} = sel ?
    {b_ready, b_rv, b_head, b_en, b_isol, b_busy, b_done, b_err} :
    {a_ready, a_rv, a_head, a_en, a_isol, a_busy, a_done, a_err};
  assign m_rd = sel ? b_rd : a_rd;

  always @(posedge clk) begin
    if (a_en) ch_a <= {ch_a[14:0], a_head};
    if (b_en) ch_b <= {ch_b[10:0], b_head};
  end

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({m_ready, m_rv, m_head, m_en, m_isol, m_busy, m_done, m_err, m_rd} !== 16'h0)
        $display("FAIL reset_outputs sel=%0d got %b expected all zero", s,
                 {m_ready, m_rv, m_head, m_en, m_isol, m_busy, m_done, m_err, m_rd});
      else passed++;
    end
  endtask

  task automatic prog(input logic s, input logic [7:0] w0, input logic [7:0] w1,
                      input int len, input int err_at, input int abort_at);
    logic [7:0] w [2];
    logic [15:0] exp_ch, got_ch;
    logic e;
    int wi = 0, pushed = 0, n_en = 0, cyc = 0;
    bit hs = 0, seen_done = 0;
    w[0] = w0; w[1] = w1;
    head_q.delete();
    sel = s;
    @(negedge clk); start = 1'b1; rd_mode = 1'b0;
    @(negedge clk); start = 1'b0;
    checks++;
    if (m_busy !== 1'b1 || m_isol !== 1'b0)
      $display("FAIL prog_start busy=%b isol_n=%b expected busy=1 isol_n=0", m_busy, m_isol);
    else passed++;
    while (!seen_done && cyc < 200) begin
      if (hs) wi++;
      hs = 0; start = 1'b0;
      if (m_en) begin
        n_en++;
        checks++;
        if (head_q.size() == 0) $display("FAIL head_extra shift %0d with no bit expected", n_en);
        else begin
          e = head_q.pop_front();
          if (m_head !== e) $display("FAIL head_bit shift %0d got %b expected %b", n_en, m_head, e);
          else passed++;
        end
        if (n_en == err_at) start = 1'b1;
        if (n_en == abort_at) begin
          rst_n = 1'b0;
          #1;
          checks++;
          if ({m_ready, m_rv, m_head, m_en, m_isol, m_busy, m_done, m_err, m_rd} !== 16'h0)
            $display("FAIL abort_outputs got %b expected all zero",
                     {m_ready, m_rv, m_head, m_en, m_isol, m_busy, m_done, m_err, m_rd});
          else passed++;
          cfg_valid = 1'b0; start = 1'b0;
          #3 rst_n = 1'b1;
          return;
        end
      end
      if (m_done) begin
        seen_done = 1;
        checks++;
        if (m_isol !== 1'b0 || m_busy !== 1'b1)
          $display("FAIL fin_state isol_n=%b busy=%b expected isol_n=0 busy=1", m_isol, m_busy);
        else passed++;
      end
      cfg_valid = 1'b0;
      if (m_ready && wi < 2) begin
        cfg_data = w[wi];
        cfg_valid = ($urandom_range(0, 2) != 0);
        if (cfg_valid) begin
          hs = 1;
          for (int k = 7; k >= 0; k--)
            if (pushed < len) begin head_q.push_back(w[wi][k]); pushed++; end
        end
      end
      @(negedge clk); cyc++;
    end
    cfg_valid = 1'b0;
    checks++;
    if (!seen_done) $display("FAIL prog_done timeout after %0d cycles expected done pulse", cyc);
    else passed++;
    checks++;
    if (n_en != len || head_q.size() != 0)
      $display("FAIL prog_shift_count got %0d shifts (%0d unused) expected %0d", n_en, head_q.size(), len);
    else passed++;
    exp_ch = {w0, w1} >> (16 - len);
    got_ch = s ? {4'b0, ch_b} : ch_a;
    checks++;
    if (got_ch !== exp_ch) $display("FAIL chain_content got %h expected %h", got_ch, exp_ch);
    else passed++;
    checks++;
    if (m_isol !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0)
      $display("FAIL prog_end isol_n=%b busy=%b done=%b expected 1 0 0", m_isol, m_busy, m_done);
    else passed++;
  endtask

  task automatic rdback(input logic s, input logic [7:0] e0, input logic [7:0] e1, input int len);
    logic [15:0] snap, got_ch;
    logic [7:0] e;
    logic isol0;
    int n_en = 0, cyc = 0, h = 0;
    bit seen_done = 0;
    sel = s;
    word_q.delete();
    word_q.push_back(e0); word_q.push_back(e1);
    snap = s ? {4'b0, ch_b} : ch_a;
    @(negedge clk); isol0 = m_isol; start = 1'b1; rd_mode = 1'b1;
    @(negedge clk); start = 1'b0; rd_mode = 1'b0;
    while (!seen_done && cyc < 300) begin
      if (rd_ready) begin rd_ready = 1'b0; h = 0; end
      else if (m_rv) begin
        checks++;
        if (m_en !== 1'b0) $display("FAIL hold_clk_en got %b expected 0", m_en);
        else passed++;
        h++;
        if (h == 6) begin
          checks++;
          if (word_q.size() == 0) $display("FAIL rd_extra got %h with no word expected", m_rd);
          else begin
            e = word_q.pop_front();
            if (m_rd !== e) $display("FAIL rd_data got %h expected %h", m_rd, e);
            else passed++;
          end
          rd_ready = 1'b1;
        end
      end
      if (m_en) n_en++;
      if (m_done) seen_done = 1;
      @(negedge clk); cyc++;
    end
    rd_ready = 1'b0;
    checks++;
    if (!seen_done || n_en != len || word_q.size() != 0)
      $display("FAIL rd_complete done=%0d shifts=%0d left=%0d expected done=1 shifts=%0d left=0",
               seen_done, n_en, word_q.size(), len);
    else passed++;
    got_ch = s ? {4'b0, ch_b} : ch_a;
    checks++;
    if (got_ch !== snap || m_isol !== isol0)
      $display("FAIL rd_preserve chain=%h isol_n=%b expected chain=%h isol_n=%b", got_ch, m_isol, snap, isol0);
    else passed++;
  endtask

  task automatic test_program();
    prog(1'b0, 8'hA5, 8'h3C, 16, 0, 0);
  endtask

  task automatic test_readback();
    rdback(1'b0, 8'hA5, 8'h3C, 16);
    rdback(1'b0, 8'hA5, 8'h3C, 16);
  endtask

  task automatic test_partial();
    prog(1'b1, 8'hFF, 8'hB7, 12, 0, 0);
    rdback(1'b1, 8'hFF, 8'hB0, 12);
  endtask

  task automatic test_err();
    prog(1'b0, 8'h5A, 8'hC3, 16, 3, 0);
    checks++;
    if (m_err !== 1'b1) $display("FAIL err_set got %b expected 1", m_err);
    else passed++;
    prog(1'b0, 8'h96, 8'h0F, 16, 0, 0);
    checks++;
    if (m_err !== 1'b0) $display("FAIL err_clear got %b expected 0", m_err);
    else passed++;
  endtask

  task automatic test_reset_mid();
    prog(1'b0, 8'h12, 8'h34, 16, 0, 6);
    prog(1'b0, 8'hA5, 8'h3C, 16, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_program();
    test_readback();
    test_partial();
    test_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ccff_chain_sequencer.md
Name: ccff_chain_sequencer

Overview:
- Sequences the configuration-chain flip-flops (ccff_head/ccff_tail scan chain) that hold per-pad settings, such as the io direction enable bits.
- Takes bitstream words from a host over valid/ready, serializes them MSB-first into the chain, and emits a clock enable for the external prog_clk gate.
- Drives the global IO isolation (isol_n) while a program runs.
- Also supports a non-destructive readback: the chain is rotated through itself and captured into words.

Parameters:
- CHAIN_LEN, 64, total number of ccff bits in the chain (>=1)
- WORD_W, 8, host word width (>=2)
- CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN

Ports:
- prog_clk  input  1  configuration clock; all state on rising edge
- pReset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins an operation when idle
- rd_mode  input  1  sampled with start: 0=program, 1=readback
- cfg_data  input  WORD_W  program word, MSB shifted first
- cfg_valid  input  1  cfg_data valid
- cfg_ready  output  1  word accepted when cfg_valid&cfg_ready
- rd_data  output  WORD_W  readback word, first captured bit in MSB
- rd_valid  output  1  rd_data valid
- rd_ready  input  1  host accepts rd_data
- ccff_head  output  1  serial data into chain
- ccff_tail  input  1  serial data out of chain
- chain_clk_en  output  1  enable for external prog_clk gate; chain shifts on the edge where this is 1
- isol_n  output  1  IO isolation, 0=isolated
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse at operation end
- err  output  1  sticky; set by start while busy, cleared by next accepted start

Behaviour:
- Reset values: cfg_ready=0, rd_valid=0, rd_data=0, ccff_head=0, chain_clk_en=0, isol_n=0, busy=0, done=0, err=0, state IDLE, counters 0.
- States: IDLE, PLOAD, PSHIFT, RSHIFT, RHOLD, FIN.
- IDLE:
  - start with rd_mode=0 -> PLOAD, isol_n<=0, busy<=1.
  - start with rd_mode=1 -> RSHIFT, busy<=1, isol_n unchanged.
  - Bit counter cleared on start.
- Start while busy: ignored and err<=1.
- PLOAD:
  - cfg_ready=1 combinationally.
  - On handshake, the word is loaded into the shift register, word_bits = min(WORD_W, CHAIN_LEN - bitcnt); go to PSHIFT.
  - With no valid word, chain_clk_en=0 and the chain holds.
- PSHIFT:
  - chain_clk_en=1 and ccff_head = shift-register MSB; both are registered/glitch-free and aligned in the same cycle.
  - Each cycle: shift left, bitcnt+1, word_bits-1.
  - When word_bits reaches 0: if bitcnt==CHAIN_LEN go to FIN, else go to PLOAD.
  - Final partial word: only its top CHAIN_LEN mod WORD_W bits are used; the rest are dropped.
- Program throughput: 1 handshake cycle + WORD_W shift cycles per full word.
- RSHIFT:
  - ccff_head = ccff_tail combinationally (rotation); chain_clk_en=1.
  - ccff_tail is captured into the rd shift register LSB with a left shift; bitcnt+1 and word_bits+1.
  - After WORD_W captures, or when bitcnt reaches CHAIN_LEN, go to RHOLD.
  - The last partial word is left-aligned and zero-padded.
- RHOLD:
  - chain_clk_en=0, rd_valid=1, rd_data stable.
  - On rd_ready: rd_valid<=0, word_bits<=0; go to FIN if bitcnt==CHAIN_LEN, else go to RSHIFT.
- After CHAIN_LEN rotations the chain content is identical to before readback.
- FIN:
  - One cycle: done=1, busy<=0; isol_n<=1 if the op was program, unchanged for readback.
  - Go to IDLE.
- chain_clk_en is never 1 outside PSHIFT/RSHIFT; exactly CHAIN_LEN enabled cycles per operation.
- Async reset mid-operation: immediately returns to reset values. isol_n=0 keeps IOs isolated; the chain content is undefined, and the host must reprogram.

Test Plan:
- CHAIN_LEN=16, WORD_W=8, program words 0xA5,0x3C with random cfg_valid gaps -> exactly 16 chain_clk_en cycles; ccff_head sequence 1010010100111100; done pulse; isol_n 0->1 on FIN.
- CHAIN_LEN=12, WORD_W=8, words 0xFF,0xB7 -> 12 shifts; last word contributes 1011; bits 0111 never driven.
- After the first test, readback with rd_ready held low 5 cycles per word -> rd_data 0xA5 then 0x3C, with chain_clk_en=0 during holds; second readback returns identical values.
- CHAIN_LEN=12 readback of the 12-bit pattern -> second rd_data is the final 4 bits left-aligned, low nibble 0.
- start pulsed during PSHIFT -> err=1, shift count unaffected; next start from IDLE clears err.
- pReset asserted mid-PSHIFT (after 5 shifts) -> same-cycle outputs at reset values, isol_n=0, busy=0; subsequent full program completes with 16 shifts.
